// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer
// Runs a programmed list of layer descriptors in order. Each layer starts one
// engine (conv/pool/fc) and waits for that engine's completion pulse before the
// next layer is issued. A watchdog, an abort input and an error code cover
// sequences that cannot finish normally.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   cfg_we/addr/engine/word  descriptor table write (accepted only when idle)
//   num_layers, start   layer count and sequence launch (accepted only when idle)
//   abort               cancels an issuing/waiting sequence, no done pulse
//   eng_valid_in        one-hot, single-cycle start pulse to the selected engine
//   eng_cfg             config word of the current layer while busy, else 0
//   eng_valid_out       per-engine completion pulses
//   busy, done          sequence active / one-cycle end-of-sequence pulse
//   err_code            0 ok, 1 bad num_layers, 2 bad engine, 3 timeout
//   layer_idx           layer currently issued or awaited
module cnn_layer_sequencer #(
  parameter int NUM_ENGINES    = 3,
  parameter int MAX_LAYERS     = 8,
  parameter int CFG_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1,
  localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1,
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [EW-1:0]          cfg_engine,
  input  logic [CFG_WIDTH-1:0]   cfg_word,
  input  logic [AW:0]            num_layers,
  input  logic                   start,
  input  logic                   abort,
  output logic [NUM_ENGINES-1:0] eng_valid_in,
  output logic [CFG_WIDTH-1:0]   eng_cfg,
  input  logic [NUM_ENGINES-1:0] eng_valid_out,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err_code,
  output logic [AW-1:0]          layer_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;

  localparam logic [1:0]    ERR_NONE = 2'd0;
  localparam logic [1:0]    ERR_NUM  = 2'd1;
  localparam logic [1:0]    ERR_ENG  = 2'd2;
  localparam logic [1:0]    ERR_TMO  = 2'd3;
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [AW:0]   NUM_ONE  = (AW+1)'(1);
  localparam logic [TW-1:0] WD_ONE   = TW'(1);
  // Last watchdog value seen before the timeout fires (counter starts at 0
  // on the first WAIT cycle).
  localparam logic [TW-1:0] WD_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e               state_q, state_d;
  logic [AW-1:0]        layer_idx_q, layer_idx_d;
  logic [AW:0]          num_q, num_d;
  logic [1:0]           err_q, err_d;
  logic [TW-1:0]        wdog_q, wdog_d;

  logic [EW-1:0]        tbl_eng_q  [MAX_LAYERS];
  logic [CFG_WIDTH-1:0] tbl_word_q [MAX_LAYERS];
  logic                 tbl_we;

  logic [EW-1:0]          cur_eng;
  logic [CFG_WIDTH-1:0]   cur_word;
  logic [NUM_ENGINES-1:0] sel_oh;
  logic                   eng_ok, eng_hit, last_layer, num_ok;

  // Table is write-protected outside IDLE so the running layer's descriptor
  // (and therefore eng_cfg) cannot change under a busy engine.
  assign tbl_we = (state_q == ST_IDLE) && cfg_we && (int'(cfg_addr) < MAX_LAYERS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        tbl_eng_q[i]  <= '0;
        tbl_word_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_eng_q[cfg_addr]  <= cfg_engine;
      tbl_word_q[cfg_addr] <= cfg_word;
    end
  end

  assign cur_eng  = tbl_eng_q[layer_idx_q];
  assign cur_word = tbl_word_q[layer_idx_q];

  // An out-of-range engine index decodes to an all-zero select, which doubles
  // as the bad-engine detector.
  always_comb begin
    sel_oh = '0;
    for (int e = 0; e < NUM_ENGINES; e++)
      if (cur_eng == EW'(e)) sel_oh[e] = 1'b1;
  end

  assign eng_ok     = |sel_oh;
  assign eng_hit    = |(sel_oh & eng_valid_out);
  assign last_layer = ({1'b0, layer_idx_q} + NUM_ONE) == num_q;
  assign num_ok     = (num_layers != '0) && (int'(num_layers) <= MAX_LAYERS);

  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    num_d       = num_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d       = ERR_NONE;
          num_d       = num_layers;
          layer_idx_d = '0;
          if (num_ok) begin
            state_d = ST_ISSUE;
          end else begin
            err_d   = ERR_NUM;
            state_d = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!eng_ok) begin
          err_d   = ERR_ENG;
          state_d = ST_DONE;
        end else begin
          wdog_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // abort > completion > timeout
        if (abort) begin
          state_d = ST_IDLE;
        end else if (eng_hit) begin
          if (last_layer) begin
            state_d = ST_DONE;
          end else begin
            layer_idx_d = layer_idx_q + IDX_ONE;
            state_d     = ST_ISSUE;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wdog_q == WD_LAST) begin
            err_d   = ERR_TMO;
            state_d = ST_DONE;
          end else begin
            wdog_d = wdog_q + WD_ONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      layer_idx_q <= '0;
      num_q       <= '0;
      err_q       <= ERR_NONE;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      num_q       <= num_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
    end
  end

  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign done         = (state_q == ST_DONE);
  // abort in the ISSUE cycle must not launch the engine.
  assign eng_valid_in = ((state_q == ST_ISSUE) && !abort) ? sel_oh : '0;
  assign eng_cfg      = busy ? cur_word : '0;
  assign err_code     = err_q;
  assign layer_idx    = layer_idx_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: directed scenarios plus
// randomized sequences, with expected issue cycles, done cycle and error
// outcome computed from the layer/latency rules by a reference model.
module tb_cnn_layer_sequencer;
  localparam int NE = 3;
  localparam int ML = 8;
  localparam int CW = 64;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  logic [1:0]    cfg_engine;
  logic [CW-1:0] cfg_word;
  logic [3:0]    num_layers;
  logic          start, abort;
  logic [NE-1:0] eng_valid_in, eng_valid_out;
  logic [CW-1:0] eng_cfg;
  logic          busy, done;
  logic [1:0]    err_code;
  logic [2:0]    layer_idx;

  int n_run, n_fail, last_done;
  logic [1:0]    m_eng  [ML];
  logic [CW-1:0] m_word [ML];
  int            lat    [ML];

  always #5 clk = ~clk;

  cnn_layer_sequencer #(
    .NUM_ENGINES(NE), .MAX_LAYERS(ML), .CFG_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_engine(cfg_engine), .cfg_word(cfg_word), .num_layers(num_layers),
    .start(start), .abort(abort), .eng_valid_in(eng_valid_in),
    .eng_cfg(eng_cfg), .eng_valid_out(eng_valid_out), .busy(busy),
    .done(done), .err_code(err_code), .layer_idx(layer_idx)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [NE-1:0] v);
    oh2idx = -1;
    for (int i = NE-1; i >= 0; i--) if (v[i]) oh2idx = i;
  endfunction

  task automatic quiet_inputs();
    start = 1'b0; cfg_we = 1'b0; abort = 1'b0; eng_valid_out = '0;
  endtask

  task automatic wr_desc(input int a, input logic [1:0] e, input logic [CW-1:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_engine = e; cfg_word = w;
    @(negedge clk);
    cfg_we = 1'b0;
    m_eng[a] = e; m_word[a] = w;
  endtask

  // One sequence: predict, drive start, act as the engines, compare.
  // abort_at < 0 means no abort.
  task automatic run_seq(input logic [3:0] n, input bit wr0, input bit noise, input int abort_at);
    int e_cyc [ML];
    logic [1:0] e_eng [ML];
    logic [CW-1:0] e_word [ML];
    int e_cnt, e_done, e_err, e_idx, t, exp_cnt, end_c, busy_end;
    int pend_c, pend_e, last_e, obs_cnt, obs_done, busy_bad, sp;
    logic [1:0] w_eng;
    logic [CW-1:0] w_word, cur_w;
    bit stop;
    w_eng  = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(NE-1));
    w_word = {$urandom, $urandom};
    if (wr0) begin m_eng[0] = w_eng; m_word[0] = w_word; end

    e_cnt = 0; e_done = -1; e_err = 0; e_idx = 0; t = 1; stop = 0;
    if (n == 0 || n > ML) begin
      e_done = 1; e_err = 1;
    end else begin
      for (int i = 0; i < int'(n) && !stop; i++) begin
        if (m_eng[i] >= NE) begin
          e_done = t + 1; e_err = 2; e_idx = i; stop = 1;
        end else begin
          e_cyc[e_cnt] = t; e_eng[e_cnt] = m_eng[i]; e_word[e_cnt] = m_word[i]; e_cnt++;
          if (lat[i] > TO) begin
            e_done = t + TO + 1; e_err = 3; e_idx = i; stop = 1;
          end else if (i == int'(n) - 1) begin
            e_done = t + lat[i] + 1; e_idx = i;
          end else begin
            t = t + lat[i] + 1;
          end
        end
      end
    end
    exp_cnt = e_cnt;
    if (abort_at >= 0) begin
      exp_cnt = 0;
      for (int i = 0; i < e_cnt; i++) if (e_cyc[i] < abort_at) exp_cnt++;
      busy_end = abort_at + 1; end_c = abort_at + 20;
    end else begin
      busy_end = e_done; end_c = e_done + 5;
    end

    @(negedge clk);
    start = 1'b1; num_layers = n;
    if (wr0) begin cfg_we = 1'b1; cfg_addr = '0; cfg_engine = w_eng; cfg_word = w_word; end
    pend_c = -1; pend_e = 0; last_e = -1; obs_cnt = 0; obs_done = -1; busy_bad = 0; cur_w = '0;
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      quiet_inputs();
      if (c == pend_c) eng_valid_out[pend_e] = 1'b1;
      if (noise && c < busy_end) begin
        sp = $urandom_range(NE-1);
        if ($urandom_range(3) == 0 && sp != last_e) eng_valid_out[sp] = 1'b1;
        if ($urandom_range(5) == 0) begin
          cfg_we = 1'b1; cfg_addr = 3'($urandom); cfg_engine = 2'($urandom); cfg_word = {$urandom, $urandom};
        end
        if ($urandom_range(5) == 0) begin start = 1'b1; num_layers = 4'($urandom_range(1, ML)); end
      end
      if (c == abort_at) abort = 1'b1;
      #1;
      if (busy !== 1'(c < busy_end)) busy_bad++;
      if (c == pend_c && c < busy_end) chk("cfg_hold", eng_cfg, cur_w);
      if (eng_valid_in != '0) begin
        last_e = oh2idx(eng_valid_in);
        chk("vin_onehot", $countones(eng_valid_in), 1);
        if (obs_cnt < exp_cnt) begin
          chk("iss_cyc", c, e_cyc[obs_cnt]);
          chk("iss_eng", last_e, e_eng[obs_cnt]);
          chk("iss_cfg", eng_cfg, e_word[obs_cnt]);
          chk("iss_idx", layer_idx, obs_cnt);
          cur_w = e_word[obs_cnt];
        end
        pend_c = -1;
        if (obs_cnt < ML && lat[obs_cnt] <= TO) begin pend_c = c + lat[obs_cnt]; pend_e = last_e; end
        obs_cnt++;
      end
      if (done === 1'b1 && obs_done < 0) begin
        obs_done = c;
        if (abort_at < 0) begin
          chk("done_err", err_code, e_err);
          chk("done_idx", layer_idx, e_idx);
        end
      end
      if (abort_at < 0 && obs_done >= 0) break;
    end
    quiet_inputs();
    chk("n_issue", obs_cnt, exp_cnt);
    chk("busy_trace", busy_bad, 0);
    if (abort_at < 0) chk("done_cyc", obs_done, e_done);
    else              chk("no_done", obs_done, -1);
    @(negedge clk); #1;
    chk("idle_done", done, 0);
    chk("err_hold", err_code, (abort_at < 0) ? e_err : 0);
    last_done = obs_done;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL tb_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int bad;
    n_run = 0; n_fail = 0; last_done = -1;
    rst = 1'b1; num_layers = '0; cfg_addr = '0; cfg_engine = '0; cfg_word = '0;
    quiet_inputs();
    for (int i = 0; i < ML; i++) begin m_eng[i] = '0; m_word[i] = '0; lat[i] = 3; end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_code, 0);
    chk("rst_idx", layer_idx, 0);
    chk("rst_vin", eng_valid_in, 0);
    chk("rst_cfg", eng_cfg, 0);
    @(negedge clk); rst = 1'b0;

    // cleared table: layer 0 is engine 0 with a zero word
    lat[0] = 3; run_seq(4'd1, 0, 0, -1);

    wr_desc(0, 2'd0, 64'hA); wr_desc(1, 2'd1, 64'hB); wr_desc(2, 2'd2, 64'hC);
    for (int i = 0; i < ML; i++) lat[i] = 6;
    run_seq(4'd3, 0, 0, -1);
    chk("tp_done22", last_done, 22);

    run_seq(4'd0, 0, 0, -1);
    run_seq(4'd9, 0, 0, -1);

    wr_desc(1, 2'd3, 64'hB);
    run_seq(4'd3, 0, 0, -1);
    wr_desc(1, 2'd1, 64'hB);

    lat[0] = TO + 1; run_seq(4'd1, 0, 0, -1);
    chk("tmo_done", last_done, TO + 2);
    lat[0] = TO;     run_seq(4'd1, 0, 0, -1);
    lat[0] = 6;

    run_seq(4'd3, 0, 0, 10);   // abort while waiting on layer 1
    run_seq(4'd3, 0, 1, -1);   // clean rerun with spurious pulses / writes / starts
    run_seq(4'd3, 0, 0, 8);    // abort in layer 1's issue cycle
    run_seq(4'd2, 1, 0, -1);   // write + start in the same cycle

    // reset in the middle of a sequence
    @(negedge clk); start = 1'b1; num_layers = 4'd3;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_code, 0);
    chk("mid_rst_idx", layer_idx, 0);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      eng_valid_out = (k == 0) ? 3'b111 : 3'b000;
      #1;
      if (done !== 1'b0 || busy !== 1'b0 || eng_valid_in !== '0) bad++;
    end
    eng_valid_out = '0;
    chk("rst_quiet", bad, 0);
    for (int i = 0; i < ML; i++) begin m_eng[i] = '0; m_word[i] = '0; end
    lat[0] = 2; run_seq(4'd1, 0, 0, -1);

    repeat (40) begin
      repeat ($urandom_range(0, 4))
        wr_desc($urandom_range(ML-1), ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(NE-1)),
                {$urandom, $urandom});
      for (int i = 0; i < ML; i++)
        lat[i] = ($urandom_range(15) == 0) ? TO + 1 : $urandom_range(1, TO);
      run_seq(($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(1, ML)),
              1'($urandom_range(1)), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
